fifo_vc_multi: RTL and testbench

//  NUM_VC independent virtual-channel FIFOs of depth 2**ADDR_SIZE behind one push port and one pop port, each selected by a VC index.

---
 rtl/fifo_vc_multi.sv | 171 +++++++++++++++++
 tb/tb_fifo_vc_multi.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_vc_multi.sv
`default_nettype none
// ============================================================================
// Module   : fifo_vc_multi
// Purpose  : NUM_VC independent virtual-channel FIFOs, each 2**ADDR_SIZE deep,
//            sharing one push port and one pop port that are steered by a VC
//            index. Each VC has its own programmable almost-full and
//            almost-empty thresholds, a hysteresis pause flag for upstream
//            flow control, and a sticky overflow/underflow error bit. The pop
//            path is registered: data_out/data_valid appear one cycle after
//            an accepted pop.
// Ports    : clk, reset (sync, active-high)
//            push, push_vc, data_in          - write request
//            pop, pop_vc                     - read request
//            af_thr, ae_thr                  - per-VC thresholds, packed
//            err_clr                         - clears sticky error bits
//            data_out, data_valid            - registered pop data / strobe
//            data_count                      - per-VC occupancy, packed
//            fifo_empty, fifo_full           - per-VC status
//            almost_full, almost_empty       - per-VC threshold status
//            fifo_pause, fifo_error          - per-VC flow control / errors
// Revision : 1.0 - initial release
// ============================================================================
module fifo_vc_multi #(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_SIZE = 2,
    parameter int NUM_VC    = 2,
    parameter int VC_SEL    = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [VC_SEL-1:0]               push_vc,
    input  logic [DATA_SIZE-1:0]            data_in,
    input  logic                            pop,
    input  logic [VC_SEL-1:0]               pop_vc,
    input  logic [NUM_VC*(ADDR_SIZE+1)-1:0] af_thr,
    input  logic [NUM_VC*(ADDR_SIZE+1)-1:0] ae_thr,
    input  logic                            err_clr,
    output logic [DATA_SIZE-1:0]            data_out,
    output logic                            data_valid,
    output logic [NUM_VC*(ADDR_SIZE+1)-1:0] data_count,
    output logic [NUM_VC-1:0]               fifo_empty,
    output logic [NUM_VC-1:0]               fifo_full,
    output logic [NUM_VC-1:0]               almost_full,
    output logic [NUM_VC-1:0]               almost_empty,
    output logic [NUM_VC-1:0]               fifo_pause,
    output logic [NUM_VC-1:0]               fifo_error
);

    localparam int c_DEPTH = 1 << ADDR_SIZE;
    localparam int c_CW    = ADDR_SIZE + 1;

    logic [NUM_VC-1:0]    w_push_acc;
    logic [NUM_VC-1:0]    w_pop_acc;
    logic [DATA_SIZE-1:0] w_rd_data [NUM_VC];
    logic [DATA_SIZE-1:0] w_pop_data;

    // Only the VC whose index matches can respond, so an out-of-range index
    // selects nothing and is ignored without raising an error.
    always_comb begin
        w_pop_data = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (pop_vc == VC_SEL'(i)) begin
                w_pop_data = w_rd_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= |w_pop_acc;
            if (|w_pop_acc) begin
                data_out <= w_pop_data;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
            logic [DATA_SIZE-1:0] r_mem [c_DEPTH];
            logic [ADDR_SIZE-1:0] r_wr_ptr;
            logic [ADDR_SIZE-1:0] r_rd_ptr;
            logic [c_CW-1:0]      r_count;
            logic [c_CW-1:0]      w_count_nxt;
            logic [c_CW-1:0]      w_af;
            logic [c_CW-1:0]      w_ae;
            logic                 w_push_sel;
            logic                 w_pop_sel;
            logic                 w_empty;
            logic                 w_full;
            logic                 w_err;
            logic                 r_pause;
            logic                 r_error;

            assign w_af       = af_thr[i*c_CW +: c_CW];
            assign w_ae       = ae_thr[i*c_CW +: c_CW];
            assign w_push_sel = push && (push_vc == VC_SEL'(i));
            assign w_pop_sel  = pop && (pop_vc == VC_SEL'(i));
            assign w_empty    = (r_count == '0);
            assign w_full     = (r_count == c_CW'(c_DEPTH));

            // A pop on the same VC frees a slot in the same cycle, so a push
            // to a full VC is still accepted when paired with it.
            assign w_pop_acc[i]  = w_pop_sel && !w_empty;
            assign w_push_acc[i] = w_push_sel && (!w_full || w_pop_acc[i]);
            assign w_err         = (w_push_sel && !w_push_acc[i]) ||
                                   (w_pop_sel && w_empty);

            assign w_rd_data[i] = r_mem[r_rd_ptr];

            always_comb begin
                w_count_nxt = r_count;
                if (w_push_acc[i] && !w_pop_acc[i]) begin
                    w_count_nxt = r_count + 1'b1;
                end else if (w_pop_acc[i] && !w_push_acc[i]) begin
                    w_count_nxt = r_count - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (w_push_acc[i] && !reset) begin
                    r_mem[r_wr_ptr] <= data_in;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                    r_pause  <= 1'b0;
                    r_error  <= 1'b0;
                end else begin
                    if (w_push_acc[i]) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop_acc[i]) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    r_count <= w_count_nxt;
                    // Hysteresis on the next-state count: between the two
                    // thresholds the pause flag keeps its previous value.
                    if (w_count_nxt >= w_af) begin
                        r_pause <= 1'b1;
                    end else if (w_count_nxt <= w_ae) begin
                        r_pause <= 1'b0;
                    end
                    // A fresh error outranks a simultaneous clear.
                    if (w_err) begin
                        r_error <= 1'b1;
                    end else if (err_clr) begin
                        r_error <= 1'b0;
                    end
                end
            end

            assign data_count[i*c_CW +: c_CW] = r_count;
            assign fifo_empty[i]   = w_empty;
            assign fifo_full[i]    = w_full;
            assign almost_full[i]  = (r_count >= w_af);
            assign almost_empty[i] = (r_count <= w_ae) && !w_empty;
            assign fifo_pause[i]   = r_pause;
            assign fifo_error[i]   = r_error;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_vc_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_vc_multi
// Purpose  : Self-checking bench for fifo_vc_multi. A queue-based reference
//            model tracks per-VC contents, errors, pause and the pop register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_vc_multi;

    localparam int c_DS  = 6;
    localparam int c_AS  = 2;
    localparam int c_NVC = 2;
    localparam int c_VS  = 1;
    localparam int c_CW  = c_AS + 1;
    localparam int c_DEP = 1 << c_AS;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   push = 1'b0;
    logic [c_VS-1:0]        push_vc = '0;
    logic [c_DS-1:0]        data_in = '0;
    logic                   pop = 1'b0;
    logic [c_VS-1:0]        pop_vc = '0;
    logic [c_NVC*c_CW-1:0]  af_thr = {3'd3, 3'd3};
    logic [c_NVC*c_CW-1:0]  ae_thr = {3'd1, 3'd1};
    logic                   err_clr = 1'b0;
    logic [c_DS-1:0]        data_out;
    logic                   data_valid;
    logic [c_NVC*c_CW-1:0]  data_count;
    logic [c_NVC-1:0]       fifo_empty;
    logic [c_NVC-1:0]       fifo_full;
    logic [c_NVC-1:0]       almost_full;
    logic [c_NVC-1:0]       almost_empty;
    logic [c_NVC-1:0]       fifo_pause;
    logic [c_NVC-1:0]       fifo_error;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [c_DS-1:0]  m_q [c_NVC][$];
    logic [c_NVC-1:0] m_err;
    logic [c_NVC-1:0] m_pause;
    logic [c_DS-1:0]  m_dout;
    logic             m_valid;

    fifo_vc_multi #(
        .DATA_SIZE(c_DS),
        .ADDR_SIZE(c_AS),
        .NUM_VC   (c_NVC),
        .VC_SEL   (c_VS)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_vc     (push_vc),
        .data_in     (data_in),
        .pop         (pop),
        .pop_vc      (pop_vc),
        .af_thr      (af_thr),
        .ae_thr      (ae_thr),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_count  (data_count),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .fifo_pause  (fifo_pause),
        .fifo_error  (fifo_error)
    );

    always #5 clk = ~clk;

    // One clock edge; the model applies the same inputs at the same edge.
    task automatic tick();
        bit pop_ok;
        bit push_ok;
        int pv;
        int wv;
        int n;
        pv = int'(pop_vc);
        wv = int'(push_vc);
        @(posedge clk);
        if (reset) begin
            for (int v = 0; v < c_NVC; v++) m_q[v].delete();
            m_err   = '0;
            m_pause = '0;
            m_dout  = '0;
            m_valid = 1'b0;
        end else begin
            pop_ok  = pop && (pv < c_NVC) && (m_q[pv].size() > 0);
            push_ok = push && (wv < c_NVC) &&
                      ((m_q[wv].size() < c_DEP) || (pop_ok && pv == wv));
            for (int v = 0; v < c_NVC; v++) begin
                if ((push && wv == v && !push_ok) ||
                    (pop && pv == v && m_q[v].size() == 0))
                    m_err[v] = 1'b1;
                else if (err_clr)
                    m_err[v] = 1'b0;
            end
            m_valid = pop_ok;
            if (pop_ok) m_dout = m_q[pv].pop_front();
            if (push_ok) m_q[wv].push_back(data_in);
            for (int v = 0; v < c_NVC; v++) begin
                n = m_q[v].size();
                if (n >= int'(af_thr[v*c_CW +: c_CW])) m_pause[v] = 1'b1;
                else if (n <= int'(ae_thr[v*c_CW +: c_CW])) m_pause[v] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; err_clr = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); idle();
        n_checks++; if (data_count !== '0) $display("FAIL reset_count act=%h exp=0", data_count); else n_pass++;
        n_checks++; if (fifo_empty !== 2'b11) $display("FAIL reset_empty act=%b exp=11", fifo_empty); else n_pass++;
        n_checks++; if ({fifo_full, almost_full, almost_empty} !== '0)
            $display("FAIL reset_flags act=%b exp=0", {fifo_full, almost_full, almost_empty}); else n_pass++;
        n_checks++; if ({fifo_pause, fifo_error, data_valid} !== '0)
            $display("FAIL reset_pause_err_valid act=%b exp=0", {fifo_pause, fifo_error, data_valid}); else n_pass++;
        n_checks++; if (data_out !== '0) $display("FAIL reset_dout act=%h exp=0", data_out); else n_pass++;
    endtask

    task automatic test_fill();
        logic [1:0] exp_pause [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        for (int k = 0; k < 4; k++) begin
            push = 1'b1; push_vc = 1'b0; data_in = 6'(k + 1);
            tick();
            n_checks++; if (fifo_pause !== exp_pause[k])
                $display("FAIL fill_pause%0d act=%b exp=%b", k, fifo_pause, exp_pause[k]); else n_pass++;
        end
        idle();
        n_checks++; if (data_count !== 6'b000_100) $display("FAIL fill_count act=%h exp=04", data_count); else n_pass++;
        n_checks++; if (fifo_full !== 2'b01) $display("FAIL fill_full act=%b exp=01", fifo_full); else n_pass++;
        n_checks++; if (fifo_empty !== 2'b10) $display("FAIL fill_empty act=%b exp=10", fifo_empty); else n_pass++;
        n_checks++; if (almost_full !== 2'b01) $display("FAIL fill_af act=%b exp=01", almost_full); else n_pass++;
    endtask

    task automatic test_overflow();
        push = 1'b1; push_vc = 1'b0; data_in = 6'h2A; tick(); idle();
        n_checks++; if (data_count !== 6'b000_100) $display("FAIL ovf_count act=%h exp=04", data_count); else n_pass++;
        n_checks++; if (fifo_error !== 2'b01) $display("FAIL ovf_err act=%b exp=01", fifo_error); else n_pass++;
        tick();
        n_checks++; if (fifo_error !== 2'b01) $display("FAIL ovf_sticky act=%b exp=01", fifo_error); else n_pass++;
        err_clr = 1'b1; tick(); idle();
        n_checks++; if (fifo_error !== 2'b00) $display("FAIL ovf_clr act=%b exp=00", fifo_error); else n_pass++;
    endtask

    task automatic test_drain();
        logic [1:0] exp_pause [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
        for (int k = 0; k < 4; k++) begin
            pop = 1'b1; pop_vc = 1'b0; tick();
            n_checks++; if (data_out !== 6'(k + 1) || data_valid !== 1'b1)
                $display("FAIL drain_data%0d act=%h/%b exp=%h/1", k, data_out, data_valid, 6'(k + 1)); else n_pass++;
            n_checks++; if (fifo_pause !== exp_pause[k])
                $display("FAIL drain_pause%0d act=%b exp=%b", k, fifo_pause, exp_pause[k]); else n_pass++;
        end
        idle(); tick();
        n_checks++; if (data_valid !== 1'b0) $display("FAIL drain_valid_low act=%b exp=0", data_valid); else n_pass++;
        n_checks++; if (fifo_empty !== 2'b11) $display("FAIL drain_empty act=%b exp=11", fifo_empty); else n_pass++;
    endtask

    task automatic test_underflow();
        pop = 1'b1; pop_vc = 1'b1; tick(); idle();
        n_checks++; if (fifo_error !== 2'b10) $display("FAIL udf_err act=%b exp=10", fifo_error); else n_pass++;
        n_checks++; if (data_valid !== 1'b0 || data_out !== 6'h04)
            $display("FAIL udf_hold act=%h/%b exp=04/0", data_out, data_valid); else n_pass++;
        // Error on the same cycle as a clear keeps the bit set.
        pop = 1'b1; pop_vc = 1'b1; err_clr = 1'b1; tick(); idle();
        n_checks++; if (fifo_error !== 2'b10) $display("FAIL udf_err_wins act=%b exp=10", fifo_error); else n_pass++;
        err_clr = 1'b1; tick(); idle();
        n_checks++; if (fifo_error !== 2'b00) $display("FAIL udf_clr act=%b exp=00", fifo_error); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_tail [3] = '{6'h23, 6'h24, 6'h11};
        for (int k = 0; k < 4; k++) begin
            push = 1'b1; push_vc = 1'b0; data_in = 6'(6'h21 + k); tick();
        end
        push = 1'b1; push_vc = 1'b0; data_in = 6'h11; pop = 1'b1; pop_vc = 1'b0; tick(); idle();
        n_checks++; if (data_count !== 6'b000_100 || fifo_error !== 2'b00)
            $display("FAIL b2b_full_pushpop act=%h/%b exp=04/00", data_count, fifo_error); else n_pass++;
        n_checks++; if (data_out !== 6'h21 || data_valid !== 1'b1)
            $display("FAIL b2b_first act=%h/%b exp=21/1", data_out, data_valid); else n_pass++;
        push = 1'b1; push_vc = 1'b1; data_in = 6'h33; pop = 1'b1; pop_vc = 1'b0; tick(); idle();
        n_checks++; if (data_count !== 6'b001_011)
            $display("FAIL b2b_cross_vc act=%h exp=0b", data_count); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            pop = 1'b1; pop_vc = 1'b0; tick();
            n_checks++; if (data_out !== exp_tail[k] || data_valid !== 1'b1)
                $display("FAIL b2b_tail%0d act=%h/%b exp=%h/1", k, data_out, data_valid, exp_tail[k]); else n_pass++;
        end
        idle();
    endtask

    task automatic test_reset_mid();
        push = 1'b1; push_vc = 1'b1; data_in = 6'h3F; pop = 1'b1; pop_vc = 1'b1; reset = 1'b1;
        tick(); idle();
        n_checks++; if (data_count !== '0 || fifo_empty !== 2'b11)
            $display("FAIL rstmid_count act=%h/%b exp=0/11", data_count, fifo_empty); else n_pass++;
        n_checks++; if ({fifo_pause, fifo_error, data_valid} !== '0)
            $display("FAIL rstmid_flags act=%b exp=0", {fifo_pause, fifo_error, data_valid}); else n_pass++;
    endtask

    task automatic test_random();
        logic [c_NVC*c_CW-1:0] exp_cnt;
        logic [c_NVC-1:0] e_em, e_fu, e_af, e_ae;
        int n;
        for (int v = 0; v < c_NVC; v++) begin
            n = int'($urandom_range(1, c_DEP));
            af_thr[v*c_CW +: c_CW] = c_CW'(n);
            ae_thr[v*c_CW +: c_CW] = c_CW'($urandom_range(0, n - 1));
        end
        reset = 1'b1; tick(); idle();
        for (int c = 0; c < 400; c++) begin
            push    = ($urandom_range(0, 99) < 60);
            push_vc = c_VS'($urandom_range(0, c_NVC - 1));
            data_in = c_DS'($urandom);
            pop     = ($urandom_range(0, 99) < 50);
            pop_vc  = c_VS'($urandom_range(0, c_NVC - 1));
            err_clr = ($urandom_range(0, 99) < 10);
            tick();
            for (int v = 0; v < c_NVC; v++) begin
                n = m_q[v].size();
                exp_cnt[v*c_CW +: c_CW] = c_CW'(n);
                e_em[v] = (n == 0);
                e_fu[v] = (n == c_DEP);
                e_af[v] = (n >= int'(af_thr[v*c_CW +: c_CW]));
                e_ae[v] = (n != 0) && (n <= int'(ae_thr[v*c_CW +: c_CW]));
            end
            n_checks++; if (data_count !== exp_cnt)
                $display("FAIL rnd_count c=%0d act=%h exp=%h", c, data_count, exp_cnt); else n_pass++;
            n_checks++; if ({fifo_empty, fifo_full, almost_full, almost_empty} !== {e_em, e_fu, e_af, e_ae})
                $display("FAIL rnd_status c=%0d act=%b exp=%b", c,
                         {fifo_empty, fifo_full, almost_full, almost_empty}, {e_em, e_fu, e_af, e_ae}); else n_pass++;
            n_checks++; if (fifo_pause !== m_pause || fifo_error !== m_err)
                $display("FAIL rnd_pause_err c=%0d act=%b/%b exp=%b/%b", c, fifo_pause, fifo_error, m_pause, m_err); else n_pass++;
            n_checks++; if (data_valid !== m_valid || data_out !== m_dout)
                $display("FAIL rnd_data c=%0d act=%h/%b exp=%h/%b", c, data_out, data_valid, m_dout, m_valid); else n_pass++;
        end
        idle();
    endtask

    initial begin
        m_err = '0; m_pause = '0; m_dout = '0; m_valid = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
